lfsr_c17_bist: RTL and testbench
================================

// Module: lfsr_c17_bist
// PURPOSE
// - Self-test pattern block: a 5-bit XNOR Fibonacci LFSR, built as a shift chain of five
//   D flip-flops, drives the ISCAS-85 c17 combinational benchmark circuit.
// - Sits between the test controller and the response checker.
// - Provides the current pattern, the two c17 responses and a wrap indication.
// PARAMETERS
// - SEED_RST  5'b00000  LFSR state loaded by reset; must not be 5'b11111.
// PORTS
// - clk          in   1  rising-edge clock; the only clock.
// - reset        in   1  asynchronous, active-low reset; 0 = reset asserted.
// - en           in   1  advance LFSR one step per clk when 1.
// - load         in   1  synchronous seed load; has priority over en.
// - seed         in   5  value loaded when load=1.
// - q            out  5  LFSR state; q[0] = newest bit, q[4] = oldest bit.
// - n22          out  1  c17 output N22.
// - n23          out  1  c17 output N23.
// - wrap         out  1  1-cycle registered pulse, asserted when a step returns q to SEED_RST.
// BEHAVIOUR
// - Reset (reset=0, asynchronous, any time, including mid-sequence):
//   - q=SEED_RST, wrap=0.
//   - n22/n23 are then the c17 function of SEED_RST (0/0 for 00000).
// - Step (en=1, load=0, rising clk):
//   - fb = ~(q[4] ^ q[2]).
//   - q <= {q[3:0], fb}, i.e. each flop takes its predecessor, q[0] takes fb.
//   - Polynomial x^5+x^3+1; period 31 from 00000; state 11111 never occurs in normal stepping.
// - Hold (en=0, load=0): q unchanged; wrap=0.
// - Load (load=1): q <= seed regardless of en.
//   - Lock-up guard: seed==5'b11111 loads 5'b00000 instead.
//   - wrap=0 on the load cycle.
// - wrap: set to 1 for exactly one cycle after a step whose next state == SEED_RST; else 0.
// - c17 is purely combinational from q, with zero-cycle latency:
//   - Input mapping: N1=q[0], N2=q[1], N3=q[2], N6=q[3], N7=q[4].
//   - N10 = NAND(N1,N3);  N11 = NAND(N3,N6).
//   - N16 = NAND(N2,N11); N19 = NAND(N11,N7).
//   - n22 = NAND(N10,N16); n23 = NAND(N16,N19).
// - No X may reach the outputs once reset has been applied.
// TESTING
// - Reset then 6 steps from 00000 -> q = 00001, 00011, 00111, 01110, 11100, 11001.
// - c17 check -> n22/n23 = 0/0 at q 00000 and 00001; 1/1 at 00011 and 00111; 0/0 at 01110 and 11100.
// - Full cycle -> 31 consecutive steps from reset give 31 distinct states, none equal to 11111;
//   wrap pulses once, after step 31, with q=00000.
// - en=0 for 5 cycles at q=00111 -> q stays 00111, n22/n23 stay 1/1.
// - load=1 with seed=01010 (and en=1) -> q=01010 next cycle; load seed=11111 -> q=00000.
// - reset=0 asserted between clock edges mid-sequence -> q=00000 immediately, with no clock
//   edge; sequence restarts at 00001 after release.
// - Exhaustive c17: load all 31 legal seeds -> n22/n23 match the NAND equations above.

Source files
------------

// File: rtl/lfsr_c17_bist.sv
// 5-bit XNOR Fibonacci LFSR pattern source driving the ISCAS-85 c17 circuit.
// Exposes the current pattern, both c17 responses and a one-cycle wrap pulse.
module lfsr_c17_bist #(
  parameter logic [4:0] SEED_RST = 5'b00000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] seed,
  output logic [4:0] q,
  output logic       n22,
  output logic       n23,
  output logic       wrap
);

  localparam logic [4:0] LOCKUP = 5'b11111;

  logic       fb;
  logic [4:0] step;
  logic [4:0] seed_safe;
  logic [4:0] d;
  logic       wrap_d;

  assign fb        = ~(q[4] ^ q[2]);
  assign step      = {q[3:0], fb};
  assign seed_safe = (seed == LOCKUP) ? 5'b00000 : seed;

  always_comb begin
    d      = q;
    wrap_d = 1'b0;
    unique case (1'b1)
      load: begin
        d      = seed_safe;
        wrap_d = 1'b0;
      end
      (!load && en): begin
        d      = step;
        wrap_d = (step == SEED_RST);
      end
      (!load && !en): begin
        d      = q;
        wrap_d = 1'b0;
      end
      default: begin
        d      = q;
        wrap_d = 1'b0;
      end
    endcase
  end

  // One D flip-flop per stage so the chain maps directly onto the shift path.
  for (genvar i = 0; i < 5; i++) begin : g_chain
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q[i] <= SEED_RST[i];
      end else begin
        q[i] <= d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_d;
    end
  end

  logic n1, n2, n3, n6, n7;
  logic n10, n11, n16, n19;

  assign n1 = q[0];
  assign n2 = q[1];
  assign n3 = q[2];
  assign n6 = q[3];
  assign n7 = q[4];

  assign n10 = ~(n1 & n3);
  assign n11 = ~(n3 & n6);
  assign n16 = ~(n2 & n11);
  assign n19 = ~(n11 & n7);
  assign n22 = ~(n10 & n16);
  assign n23 = ~(n16 & n19);

endmodule

// File: tb/tb_lfsr_c17_bist.sv
// Self-checking bench for lfsr_c17_bist: fixed vectors, corner sequences
// and random stimulus against an arithmetic reference model.
module tb_lfsr_c17_bist;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [4:0] seed;
  logic [4:0] q;
  logic       n22;
  logic       n23;
  logic       wrap;

  int checks;
  int errors;

  lfsr_c17_bist #(.SEED_RST(5'b00000)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .load (load),
    .seed (seed),
    .q    (q),
    .n22  (n22),
    .n23  (n23),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [4:0] seed;
    logic [4:0] q;
    logic       n22;
    logic       n23;
    logic       wrap;
  } vec_t;

  function automatic logic [4:0] m_next(input logic [4:0] s);
    int v;
    int f;
    v = int'(s);
    f = 1 - (((v / 16) + (v / 4)) % 2);
    return 5'((v * 2) % 32 + f);
  endfunction

  function automatic logic [1:0] m_c17(input logic [4:0] s);
    logic a1, a2, a3, a6, a7, r22, r23;
    {a7, a6, a3, a2, a1} = s;
    r22 = (a1 & a3) | (a2 & ~(a3 & a6));
    r23 = ~(a3 & a6) & (a2 | a7);
    return {r22, r23};
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got q/n22/n23/wrap=%b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic l, input logic [4:0] s);
    en   = e;
    load = l;
    seed = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    seed  = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {q, n22, n23, wrap}, 8'b00000_000);
    reset = 1'b1;
  endtask

  vec_t vt[$];
  logic [4:0] mq;
  logic       mw;
  logic [31:0] seen;
  logic [1:0] c;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    seed   = 5'b0;

    vt.push_back('{1, 0, 5'b00000, 5'b00001, 0, 0, 0});
    vt.push_back('{1, 0, 5'b00000, 5'b00011, 1, 1, 0});
    vt.push_back('{1, 0, 5'b00000, 5'b00111, 1, 1, 0});
    for (int i = 0; i < 5; i++)
      vt.push_back('{0, 0, 5'b10101, 5'b00111, 1, 1, 0});
    vt.push_back('{1, 0, 5'b00000, 5'b01110, 0, 0, 0});
    vt.push_back('{1, 0, 5'b00000, 5'b11100, 0, 0, 0});
    vt.push_back('{1, 0, 5'b00000, 5'b11001, 0, 1, 0});
    vt.push_back('{1, 1, 5'b01010, 5'b01010, 1, 1, 0});
    vt.push_back('{0, 1, 5'b11111, 5'b00000, 0, 0, 0});
    vt.push_back('{1, 0, 5'b00000, 5'b00001, 0, 0, 0});

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].en, vt[i].load, vt[i].seed);
      chk($sformatf("vec%0d", i), {q, n22, n23, wrap},
          {vt[i].q, vt[i].n22, vt[i].n23, vt[i].wrap});
    end

    // Full period from reset.
    do_reset();
    seen = '0;
    seen[0] = 1'b1;
    mq = 5'b0;
    for (int i = 1; i <= 31; i++) begin
      cyc(1, 0, 5'b0);
      mq = m_next(mq);
      chk($sformatf("period%0d", i), {q, n22, n23, wrap},
          {mq, m_c17(mq), (i == 31)});
      if (i < 31) begin
        checks++;
        if (q == 5'b11111 || seen[q]) begin
          errors++;
          $display("FAIL period_distinct: got q=%b repeated/lockup want new state", q);
        end
        seen[q] = 1'b1;
      end
    end
    chk("period_end", {q, wrap}, {5'b00000, 1'b1});
    cyc(0, 0, 5'b0);
    chk("wrap_clear", {q, n22, n23, wrap}, 8'b00000_000);

    // Asynchronous reset between edges.
    repeat (4) cyc(1, 0, 5'b0);
    chk("pre_areset", {q, n22, n23, wrap}, {5'b01110, 3'b000});
    #3;
    reset = 1'b0;
    #1;
    chk("areset_now", {q, n22, n23, wrap}, 8'b00000_000);
    #1;
    reset = 1'b1;
    cyc(1, 0, 5'b0);
    chk("areset_restart", {q, n22, n23, wrap}, {5'b00001, 3'b000});

    // Every legal seed, plus the lock-up guard.
    for (int s = 0; s < 32; s++) begin
      cyc(s[0], 1, 5'(s));
      mq = (s == 31) ? 5'b0 : 5'(s);
      chk($sformatf("seed%0d", s), {q, n22, n23, wrap},
          {mq, m_c17(mq), 1'b0});
    end

    // Random traffic against the model.
    do_reset();
    mq = 5'b0;
    mw = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic e, l;
      logic [4:0] s;
      e = 1'($urandom_range(0, 3) != 0);
      l = 1'($urandom_range(0, 9) == 0);
      s = 5'($urandom);
      cyc(e, l, s);
      if (l) begin
        mq = (s == 5'b11111) ? 5'b0 : s;
        mw = 1'b0;
      end else if (e) begin
        mq = m_next(mq);
        mw = (mq == 5'b0);
      end else begin
        mw = 1'b0;
      end
      c = m_c17(mq);
      chk($sformatf("rand%0d", i), {q, n22, n23, wrap}, {mq, c, mw});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
